// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} with flush and valid/ready on
// both sides. Define IFQ_BYPASS_EN to forward fetch straight to decode while the queue is empty.
module if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [31:0]             in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [31:0]             out_instr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [31:0]   NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e          state;
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, bypass, consumed;

    always_comb begin
        if (count_q == '0) begin
            state = StEmpty;
        end else if (count_q == DepthCnt) begin
            state = StFull;
        end else begin
            state = StPartial;
        end
    end

    // Registered-only, so decode backpressure never reaches fetch combinationally.
    assign in_ready = (state != StFull);
    assign count    = count_q;

    always_comb begin
        out_valid = (state != StEmpty) & ~flush;
        out_pc    = pc_mem[rd_ptr_q];
        out_instr = instr_mem[rd_ptr_q];
        bypass    = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (state == StEmpty) begin
            bypass    = 1'b1;
            out_valid = in_valid & ~flush;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
        // Decode sees a NOP at pc 0 whenever nothing valid is offered.
        if (!out_valid) begin
            out_pc    = '0;
            out_instr = NopInstr;
        end
    end

    assign push     = in_valid & in_ready & ~flush;
    assign pop      = out_valid & out_ready & ~flush;
    // A bypassed entry taken in the same cycle never touches storage or pointers.
    assign consumed = bypass & push & pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!consumed) begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !consumed && !reset) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue (DEPTH = 2); adapts bypass-dependent checks to IFQ_BYPASS_EN.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 64;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [31:0]     in_instr, out_instr;
    logic [CW-1:0]   count;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    logic [95:0] sb [$];

    if_id_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [95:0] e;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back({in_pc, in_instr});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 64'(out_pc), 64'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check("pop_pc", out_pc, e[95:32]);
                    check("pop_instr", 64'(out_instr), 64'(e[31:0]));
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_out_pc", out_pc, 64'd0);
        cyc();

        // Fill with decode stalled, then drain in order.
        in_valid = 1'b1; in_pc = 64'h1000; in_instr = 32'h0050_0093;
        cyc();
        in_pc = 64'h1004; in_instr = 32'hFFF1_0113;
        cyc();
        in_pc = 64'hDEAD; in_instr = 32'hBAD0_BAD0;
        @(negedge clk);
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_pc", out_pc, 64'h1000);
        check("full_head_instr", 64'(out_instr), 64'h0050_0093);
        cyc();
        in_pc = 64'hBEEF;
        @(negedge clk);
        check("hold_pc", out_pc, 64'h1000);
        check("hold_count", 64'(count), 64'd2);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("pop_full_in_ready", 64'(in_ready), 64'd1);
        check("pop1_count", 64'(count), 64'd1);
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_count", 64'(count), 64'd0);
        check("drain_nop", 64'(out_instr), 64'h13);
        cyc();

        // Streaming at one entry per cycle.
        p0 = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_pc    = 64'h2000 + 64'(4 * i);
            in_instr = 32'h0000_0093 + 32'(i << 20);
            @(negedge clk);
`ifdef IFQ_BYPASS_EN
            check("stream_count", 64'(count), 64'd0);
            check("stream_valid", 64'(out_valid), 64'd1);
`else
            if (i > 0) begin
                check("stream_count", 64'(count), 64'd1);
                check("stream_valid", 64'(out_valid), 64'd1);
            end
`endif
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cyc(); cyc();
        check("stream_pops", 64'(pop_cnt - p0), 64'd10);
        check("stream_end_count", 64'(count), 64'd0);

        // Flush a full queue while fetch offers pc 0x3000.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 64'h3100; in_instr = 32'h0000_0001;
        cyc();
        in_pc = 64'h3104; in_instr = 32'h0000_0002;
        cyc();
        in_pc = 64'h3000; in_instr = 32'h0000_0003; flush = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_valid", 64'(out_valid), 64'd0);
        check("post_flush_pc", out_pc, 64'd0);
        cyc();
        @(negedge clk);
        check("post_flush_valid2", 64'(out_valid), 64'd0);
        cyc();

        // Simultaneous push and pop at count 1.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 64'h5000; in_instr = 32'h0000_5000;
        cyc();
        in_pc = 64'h5004; in_instr = 32'h0000_5004; out_ready = 1'b1;
        @(negedge clk);
        check("pp_count_before", 64'(count), 64'd1);
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("pp_count_after", 64'(count), 64'd1);
        check("pp_new_head", out_pc, 64'h5004);
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("pp_drain", 64'(count), 64'd0);

        // Empty queue, decode ready: bypass forwards in the same cycle, otherwise one cycle later.
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 64'h4000; in_instr = 32'h0010_0073;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_pc", out_pc, 64'h4000);
        check("byp_instr", 64'(out_instr), 64'h0010_0073);
        cyc();
        in_valid = 1'b0;
        check("byp_count", 64'(count), 64'd0);
`else
        check("nobyp_valid", 64'(out_valid), 64'd0);
        check("nobyp_instr", 64'(out_instr), 64'h13);
        cyc();
        in_valid = 1'b0;
        check("nobyp_count", 64'(count), 64'd1);
        check("nobyp_pc", out_pc, 64'h4000);
        cyc();
        check("nobyp_drain", 64'(count), 64'd0);
`endif
        out_ready = 1'b0;

        // Reset mid-operation drops queued and offered entries.
        in_valid = 1'b1; in_pc = 64'h6000; in_instr = 32'h0000_6000;
        cyc();
        reset = 1'b1; in_pc = 64'h6004;
        cyc();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
